prog_loader: RTL and testbench

PROG_LOADER -- requirements
Module: prog_loader

---
 rtl/prog_loader.sv | 167 ++++++++++++++++
 tb/tb_prog_loader.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/prog_loader.sv
// Program loader: receives a byte stream (16-bit little-endian word count,
// then count 32-bit little-endian words) and writes each word into the
// instruction memory starting at BASE_ADDR. After the last word it releases
// the CPU via cpu_enable. It flags a bad header on error.
// Optional feature macro: LOADER_CHECKSUM_EN adds a trailing XOR checksum byte.
module prog_loader #(
  parameter int unsigned MAX_WORDS = 128,
  parameter logic [63:0] BASE_ADDR = 64'd0
) (
  input  logic        clk,
  input  logic        arst_n,
  input  logic        in_valid,
  input  logic [7:0]  in_data,
  output logic        in_ready,
  input  logic        start,
  output logic [63:0] addr_ext,
  output logic        wen_ext,
  output logic [31:0] wdata_ext,
  output logic        cpu_enable,
  output logic        error,
  output logic [15:0] words_loaded
);

  typedef enum logic [2:0] {
    HDR_LO,
    HDR_HI,
    DATA,
    WRITE,
`ifdef LOADER_CHECKSUM_EN
    CHK,
`endif
    DONE,
    ERR
  } state_t;

  state_t      state;
  state_t      state_next;
  logic        accept;
  logic [7:0]  count_lo;
  logic [15:0] word_count;
  logic [15:0] hdr_count;
  logic        hdr_bad;
  logic        last_word;
  logic [1:0]  byte_idx;
  logic [23:0] word_buf;
`ifdef LOADER_CHECKSUM_EN
  logic [7:0]  checksum;
`endif

  assign accept    = in_valid && in_ready;
  assign hdr_count = {in_data, count_lo};
  assign hdr_bad   = (hdr_count == 16'd0) || ({16'd0, hdr_count} > MAX_WORDS);
  assign last_word = (words_loaded + 16'd1) == word_count;

  assign wen_ext    = (state == WRITE);
  assign cpu_enable = (state == DONE);
  assign error      = (state == ERR);

  // State register; reset aborts any load in progress.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state <= HDR_LO;
    end else begin
      state <= state_next;
    end
  end

  // Next-state and ready decode.
  always_comb begin
    state_next = state;
    in_ready   = 1'b0;
    case (state)
      HDR_LO: begin
        in_ready = 1'b1;
        if (accept) state_next = HDR_HI;
      end
      HDR_HI: begin
        in_ready = 1'b1;
        if (accept) state_next = hdr_bad ? ERR : DATA;
      end
      DATA: begin
        in_ready = 1'b1;
        if (accept && (byte_idx == 2'd3)) state_next = WRITE;
      end
      WRITE: begin
`ifdef LOADER_CHECKSUM_EN
        state_next = last_word ? CHK : DATA;
`else
        state_next = last_word ? DONE : DATA;
`endif
      end
`ifdef LOADER_CHECKSUM_EN
      CHK: begin
        in_ready = 1'b1;
        if (accept) state_next = (in_data == checksum) ? DONE : ERR;
      end
`endif
      DONE: begin
        if (start) state_next = HDR_LO;
      end
      ERR: begin
        if (start) state_next = HDR_LO;
      end
      default: state_next = HDR_LO;
    endcase
  end

  // Header capture, word assembly, write address/data and word counter.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      count_lo     <= 8'd0;
      word_count   <= 16'd0;
      byte_idx     <= 2'd0;
      word_buf     <= 24'd0;
      addr_ext     <= BASE_ADDR;
      wdata_ext    <= 32'd0;
      words_loaded <= 16'd0;
    end else begin
      case (state)
        HDR_LO: begin
          if (accept) count_lo <= in_data;
        end
        HDR_HI: begin
          if (accept) begin
            word_count <= hdr_count;
            byte_idx   <= 2'd0;
          end
        end
        DATA: begin
          if (accept) begin
            byte_idx <= byte_idx + 2'd1;
            case (byte_idx)
              2'd0: word_buf[7:0]   <= in_data;
              2'd1: word_buf[15:8]  <= in_data;
              2'd2: word_buf[23:16] <= in_data;
              default: begin
                wdata_ext <= {in_data, word_buf};
                addr_ext  <= BASE_ADDR + {46'd0, words_loaded, 2'b00};
              end
            endcase
          end
        end
        WRITE: begin
          words_loaded <= words_loaded + 16'd1;
        end
        DONE, ERR: begin
          if (start) words_loaded <= 16'd0;
        end
        default: ;
      endcase
    end
  end

`ifdef LOADER_CHECKSUM_EN
  // Running XOR of payload bytes, restarted with each new header.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      checksum <= 8'd0;
    end else if (state == HDR_HI && accept) begin
      checksum <= 8'd0;
    end else if (state == DATA && accept) begin
      checksum <= checksum ^ in_data;
    end
  end
`endif

endmodule

// File: tb/tb_prog_loader.sv
// Directed testbench for prog_loader (default parameters).
// Also covers the LOADER_CHECKSUM_EN build when that macro is defined.
module tb_prog_loader;

  logic        clk;
  logic        arst_n;
  logic        in_valid;
  logic [7:0]  in_data;
  logic        in_ready;
  logic        start;
  logic [63:0] addr_ext;
  logic        wen_ext;
  logic [31:0] wdata_ext;
  logic        cpu_enable;
  logic        error;
  logic [15:0] words_loaded;

  int compared   = 0;
  int mismatched = 0;

  logic [63:0] wr_addr [$];
  logic [31:0] wr_data [$];

  prog_loader dut (
    .clk          (clk),
    .arst_n       (arst_n),
    .in_valid     (in_valid),
    .in_data      (in_data),
    .in_ready     (in_ready),
    .start        (start),
    .addr_ext     (addr_ext),
    .wen_ext      (wen_ext),
    .wdata_ext    (wdata_ext),
    .cpu_enable   (cpu_enable),
    .error        (error),
    .words_loaded (words_loaded)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Record every write pulse, sampled mid-cycle.
  always @(negedge clk) begin
    if (wen_ext === 1'b1) begin
      wr_addr.push_back(addr_ext);
      wr_data.push_back(wdata_ext);
    end
  end

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    compared++;
    assert (observed === expected)
    else begin
      mismatched++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  // Present one byte and hold it until an edge with in_ready high takes it.
  task automatic applyStimulus(input logic [7:0] b);
    int   waited;
    logic rdy;
    waited   = 0;
    in_valid = 1'b1;
    in_data  = b;
    do begin
      @(negedge clk);
      rdy = in_ready;
      @(posedge clk);
      #1;
      waited++;
    end while (!rdy && waited < 20);
    if (!rdy) checkOutput("accept_timeout", {63'd0, rdy}, 64'd1);
  endtask

  // One idle cycle with a junk byte and in_valid low, then the real byte.
  task automatic applyGapped(input logic [7:0] b);
    in_valid = 1'b0;
    in_data  = 8'hFF;
    @(posedge clk);
    #1;
    applyStimulus(b);
  endtask

  // Step from the final WRITE cycle to DONE (through CHK when enabled).
  task automatic finishLoad(input logic [7:0] csum);
`ifdef LOADER_CHECKSUM_EN
    applyStimulus(csum);
`else
    if (csum == 8'h00) in_data = 8'h00;
    @(posedge clk);
    #1;
`endif
    in_valid = 1'b0;
  endtask

  task automatic pulseStart();
    in_valid = 1'b0;
    start    = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  initial begin
    arst_n   = 1'b0;
    in_valid = 1'b0;
    in_data  = 8'h00;
    start    = 1'b0;
    #3;
    checkOutput("rst_wen", {63'd0, wen_ext}, 64'd0);
    checkOutput("rst_addr", addr_ext, 64'd0);
    checkOutput("rst_wdata", {32'd0, wdata_ext}, 64'd0);
    checkOutput("rst_cpu_en", {63'd0, cpu_enable}, 64'd0);
    checkOutput("rst_error", {63'd0, error}, 64'd0);
    checkOutput("rst_words", {48'd0, words_loaded}, 64'd0);
    repeat (2) @(posedge clk);
    #1;
    arst_n = 1'b1;
    #1;
    checkOutput("rst_ready", {63'd0, in_ready}, 64'd1);

    // Two-word image with in_valid held high throughout.
    $display("[TB] two-word load");
    applyStimulus(8'h02);
    applyStimulus(8'h00);
    applyStimulus(8'h13);
    applyStimulus(8'h00);
    applyStimulus(8'h00);
    applyStimulus(8'h00);
    checkOutput("w0_wen", {63'd0, wen_ext}, 64'd1);
    checkOutput("w0_ready", {63'd0, in_ready}, 64'd0);
    applyStimulus(8'h93);
    applyStimulus(8'h00);
    applyStimulus(8'h10);
    applyStimulus(8'h00);
    checkOutput("w1_wen", {63'd0, wen_ext}, 64'd1);
    checkOutput("w1_addr", addr_ext, 64'd4);
    checkOutput("w1_data", {32'd0, wdata_ext}, 64'h0010_0093);
    checkOutput("w1_cpu_en", {63'd0, cpu_enable}, 64'd0);
    finishLoad(8'h90);
    checkOutput("l1_cpu_en", {63'd0, cpu_enable}, 64'd1);
    checkOutput("l1_wen_off", {63'd0, wen_ext}, 64'd0);
    checkOutput("l1_words", {48'd0, words_loaded}, 64'd2);
    checkOutput("l1_addr_hold", addr_ext, 64'd4);
    checkOutput("l1_wcount", wr_addr.size(), 64'd2);
    if (wr_addr.size() >= 2) begin
      checkOutput("l1_wr0_addr", wr_addr[0], 64'd0);
      checkOutput("l1_wr0_data", {32'd0, wr_data[0]}, 64'h0000_0013);
      checkOutput("l1_wr1_addr", wr_addr[1], 64'd4);
      checkOutput("l1_wr1_data", {32'd0, wr_data[1]}, 64'h0010_0093);
    end

    // Re-arm from DONE, then a one-word load with gapped valid.
    $display("[TB] restart and gapped one-word load");
    pulseStart();
    checkOutput("rs_cpu_en", {63'd0, cpu_enable}, 64'd0);
    checkOutput("rs_words", {48'd0, words_loaded}, 64'd0);
    checkOutput("rs_ready", {63'd0, in_ready}, 64'd1);
    applyGapped(8'h01);
    applyGapped(8'h00);
    applyGapped(8'hDE);
    pulseStart();
    checkOutput("dstart_cpu_en", {63'd0, cpu_enable}, 64'd0);
    checkOutput("dstart_error", {63'd0, error}, 64'd0);
    checkOutput("dstart_ready", {63'd0, in_ready}, 64'd1);
    applyGapped(8'hAD);
    applyGapped(8'hBE);
    applyGapped(8'hEF);
    checkOutput("g_wen", {63'd0, wen_ext}, 64'd1);
    checkOutput("g_ready", {63'd0, in_ready}, 64'd0);
    checkOutput("g_addr", addr_ext, 64'd0);
    checkOutput("g_data", {32'd0, wdata_ext}, 64'hEFBE_ADDE);
    finishLoad(8'h22);
    checkOutput("g_cpu_en", {63'd0, cpu_enable}, 64'd1);
    checkOutput("g_words", {48'd0, words_loaded}, 64'd1);
    checkOutput("g_wcount", wr_addr.size(), 64'd3);

    // Bad headers: zero count, then count above MAX_WORDS.
    $display("[TB] bad headers");
    pulseStart();
    applyStimulus(8'h00);
    applyStimulus(8'h00);
    in_valid = 1'b0;
    checkOutput("h0_error", {63'd0, error}, 64'd1);
    checkOutput("h0_cpu_en", {63'd0, cpu_enable}, 64'd0);
    checkOutput("h0_ready", {63'd0, in_ready}, 64'd0);
    pulseStart();
    checkOutput("h0_clear", {63'd0, error}, 64'd0);
    applyStimulus(8'h81);
    applyStimulus(8'h00);
    in_valid = 1'b0;
    checkOutput("h81_error", {63'd0, error}, 64'd1);
    checkOutput("h81_cpu_en", {63'd0, cpu_enable}, 64'd0);
    @(posedge clk);
    #1;
    checkOutput("hdr_wcount", wr_addr.size(), 64'd3);

    // Reset in the middle of a three-word load.
    $display("[TB] reset mid-load");
    pulseStart();
    applyStimulus(8'h03);
    applyStimulus(8'h00);
    applyStimulus(8'hAA);
    applyStimulus(8'hBB);
    in_valid = 1'b0;
    arst_n   = 1'b0;
    #1;
    checkOutput("mr_wen", {63'd0, wen_ext}, 64'd0);
    checkOutput("mr_addr", addr_ext, 64'd0);
    checkOutput("mr_wdata", {32'd0, wdata_ext}, 64'd0);
    checkOutput("mr_words", {48'd0, words_loaded}, 64'd0);
    repeat (2) @(posedge clk);
    #1;
    arst_n = 1'b1;
    #1;
    checkOutput("mr_ready", {63'd0, in_ready}, 64'd1);
    checkOutput("mr_wcount", wr_addr.size(), 64'd3);
    applyStimulus(8'h01);
    applyStimulus(8'h00);
    applyStimulus(8'h44);
    applyStimulus(8'h33);
    applyStimulus(8'h22);
    applyStimulus(8'h11);
    checkOutput("fr_addr", addr_ext, 64'd0);
    checkOutput("fr_data", {32'd0, wdata_ext}, 64'h1122_3344);
    finishLoad(8'h44);
    checkOutput("fr_cpu_en", {63'd0, cpu_enable}, 64'd1);
    checkOutput("fr_words", {48'd0, words_loaded}, 64'd1);
    checkOutput("fr_wcount", wr_addr.size(), 64'd4);

`ifdef LOADER_CHECKSUM_EN
    // Checksum accept and reject.
    $display("[TB] checksum");
    pulseStart();
    applyStimulus(8'h01);
    applyStimulus(8'h00);
    applyStimulus(8'h13);
    applyStimulus(8'h00);
    applyStimulus(8'h00);
    applyStimulus(8'h00);
    applyStimulus(8'h13);
    in_valid = 1'b0;
    checkOutput("ck_good_cpu", {63'd0, cpu_enable}, 64'd1);
    checkOutput("ck_good_err", {63'd0, error}, 64'd0);
    pulseStart();
    applyStimulus(8'h01);
    applyStimulus(8'h00);
    applyStimulus(8'h13);
    applyStimulus(8'h00);
    applyStimulus(8'h00);
    applyStimulus(8'h00);
    applyStimulus(8'h12);
    in_valid = 1'b0;
    checkOutput("ck_bad_err", {63'd0, error}, 64'd1);
    checkOutput("ck_bad_cpu", {63'd0, cpu_enable}, 64'd0);
`endif

    repeat (2) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
